pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage MIPS pipeline: load-use stalls, branch/jump flushes,
//  and pipeline freeze while Data_Memory is not ready. Sits beside the
//  IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives their write and flush

---
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS pipeline: load-use stall, branch/jump flush,
// memory-wait freeze with timeout. Define HAZARD_PERF_CNT_EN to add stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rt_used,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic       ex_branch_tk,
    input  logic       id_jump,
    input  logic       mem_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       idex_flush,
    output logic       exmem_write,
    output logic       memwb_bubble,
    output logic       mem_error
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WCW = $clog2(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           freeze, loaduse;

    assign freeze  = mem_req & ~mem_ready;
    assign loaduse = idex_memread & (idex_rt != 5'd0) &
                     ((idex_rt == id_rs) | (id_rt_used & (idex_rt == id_rt)));

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_flush   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        // Everything stays quiet while reset is held, even combinationally.
        if (reset) begin
            case (state_q)
                S_RUN, S_WAIT: begin
                    if (freeze) begin
                        memwb_bubble = 1'b1;
                    end else if (ex_branch_tk) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        exmem_write = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                    end else if (loaduse) begin
                        exmem_write = 1'b1;
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        exmem_write = 1'b1;
                        ifid_flush  = id_jump;
                    end

                    if (state_q == S_RUN) begin
                        if (freeze) begin
                            state_d    = S_WAIT;
                            wait_cnt_d = WCW'(1);
                        end
                    end else if (!freeze) begin
                        state_d    = S_RUN;
                        wait_cnt_d = '0;
                    end else if (wait_cnt_q == WCW'(MEM_TIMEOUT - 1)) begin
                        state_d = S_ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WCW'(1);
                    end
                end
                S_ERROR: state_d = S_ERROR;
                default: begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            endcase
        end
    end

    assign mem_error = (state_q == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             run_or_wait;

    assign run_or_wait = (state_q == S_RUN) || (state_q == S_WAIT);

    // Saturating: the counters stick at all-ones rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (run_or_wait && !pc_write && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ifid_flush && !(&flush_cnt_q))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: hand table, multi-cycle memory-wait sequences,
// and random traffic against a streak-counting reference model.
module tb_pipeline_hazard_ctrl;

    localparam int T     = 16;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       used;
        logic       memrd;
        logic [4:0] exrt;
        logic       br;
        logic       jmp;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        string      name;
        in_t        in;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    in_t  cur;
    logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush;
    logic exmem_write, memwb_bubble, mem_error;
    logic [7:0] dut_out;

    int checks = 0;
    int errors = 0;
    int streak = 0;
    bit err_m  = 1'b0;
    int stall_m = 0;
    int flush_m = 0;

    always #5 clk = ~clk;

    assign dut_out = {pc_write, ifid_write, ifid_flush, idex_bubble,
                      idex_flush, exmem_write, memwb_bubble, mem_error};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (cur.rs),
        .id_rt        (cur.rt),
        .id_rt_used   (cur.used),
        .idex_memread (cur.memrd),
        .idex_rt      (cur.exrt),
        .ex_branch_tk (cur.br),
        .id_jump      (cur.jmp),
        .mem_req      (cur.req),
        .mem_ready    (cur.rdy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .idex_flush   (idex_flush),
        .exmem_write  (exmem_write),
        .memwb_bubble (memwb_bubble),
        .mem_error    (mem_error)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    function automatic in_t mk(int rs, int rt, bit used, bit memrd, int exrt,
                               bit br, bit jmp, bit req, bit rdy);
        in_t i;
        i.rs = 5'(rs); i.rt = 5'(rt); i.used = used; i.memrd = memrd;
        i.exrt = 5'(exrt); i.br = br; i.jmp = jmp; i.req = req; i.rdy = rdy;
        return i;
    endfunction

    // Bits: pc, ifid_w, ifid_flush, idex_bubble, idex_flush, exmem_w, memwb_bubble, mem_error
    function automatic logic [7:0] model_out(in_t i, bit err, logic rst);
        bit lu;
        lu = i.memrd && i.exrt != 0 && (i.exrt == i.rs || (i.used && i.exrt == i.rt));
        if (!rst)             return 8'b0000_0000;
        if (err)              return 8'b0000_0001;
        if (i.req && !i.rdy)  return 8'b0000_0010;
        if (i.br)             return 8'b1110_1100;
        if (lu)               return 8'b0001_0100;
        if (i.jmp)            return 8'b1110_0100;
        return 8'b1100_0100;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(in_t i);
        logic [7:0] o;
        int maxc;
        maxc = (1 << CNT_W) - 1;
        o = model_out(i, err_m, reset);
        if (!reset) begin
            err_m = 0; streak = 0; stall_m = 0; flush_m = 0;
        end else if (!err_m) begin
            if (!o[7] && stall_m < maxc) stall_m++;
            if (o[5] && flush_m < maxc) flush_m++;
            if (i.req && !i.rdy) begin
                streak++;
                if (streak >= T) err_m = 1;
            end else begin
                streak = 0;
            end
        end
    endtask

    task automatic step(in_t i, string nm);
        cur = i;
        @(negedge clk);
        check(nm, {24'd0, dut_out}, {24'd0, model_out(i, err_m, reset)});
`ifdef HAZARD_PERF_CNT_EN
        check({nm, "_stallcnt"}, 32'(stall_cnt), reset ? 32'(stall_m) : 32'd0);
        check({nm, "_flushcnt"}, 32'(flush_cnt), reset ? 32'(flush_m) : 32'd0);
`endif
        @(posedge clk);
        model_edge(i);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
        reset = 1'b1;
    endtask

    vec_t tbl[10];
    in_t  frz, idle;
    int   cyc;

    initial begin
        reset = 1'b0;
        cur   = '0;
        frz   = mk(1, 2, 1, 0, 0, 0, 0, 1, 0);
        idle  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0);

        tbl[0] = '{"lu_rs",        mk(2, 0, 1, 1, 2, 0, 0, 0, 0), 8'b0001_0100};
        tbl[1] = '{"lu_r0",        mk(0, 0, 1, 1, 0, 0, 0, 0, 0), 8'b1100_0100};
        tbl[2] = '{"rt_unused",    mk(3, 5, 0, 1, 5, 0, 0, 0, 0), 8'b1100_0100};
        tbl[3] = '{"lu_rt",        mk(3, 5, 1, 1, 5, 0, 0, 0, 0), 8'b0001_0100};
        tbl[4] = '{"br_over_lu",   mk(2, 0, 1, 1, 2, 1, 0, 0, 0), 8'b1110_1100};
        tbl[5] = '{"jump",         mk(4, 6, 1, 0, 7, 0, 1, 0, 0), 8'b1110_0100};
        tbl[6] = '{"lu_over_jump", mk(7, 0, 0, 1, 7, 0, 1, 0, 0), 8'b0001_0100};
        tbl[7] = '{"frz_over_br",  mk(2, 0, 1, 1, 2, 1, 0, 1, 0), 8'b0000_0010};
        tbl[8] = '{"mem_done_jmp", mk(4, 6, 1, 0, 7, 0, 1, 1, 1), 8'b1110_0100};
        tbl[9] = '{"no_memrd",     mk(9, 9, 1, 0, 9, 0, 0, 0, 0), 8'b1100_0100};

        do_reset();

        for (int k = 0; k < 10; k++) begin
            cur = tbl[k].in;
            @(negedge clk);
            check(tbl[k].name, {24'd0, dut_out}, {24'd0, tbl[k].exp});
            @(posedge clk);
            model_edge(tbl[k].in);
            #1;
        end

        // Three frozen cycles, then the access completes.
        for (int k = 0; k < 3; k++) step(frz, "frz3");
        step(mk(1, 2, 1, 0, 0, 0, 0, 1, 1), "frz3_done");
        step(idle, "frz3_after");

`ifdef HAZARD_PERF_CNT_EN
        do_reset();
        step(mk(2, 0, 1, 1, 2, 0, 0, 0, 0), "pc_stall1");
        step(mk(2, 0, 1, 1, 2, 0, 0, 0, 0), "pc_stall2");
        step(mk(4, 6, 1, 0, 7, 0, 1, 0, 0), "pc_flush");
        check("stall_cnt_2", 32'(stall_cnt), 32'd2);
        check("flush_cnt_1", 32'(flush_cnt), 32'd1);
`endif

        // Hung access: mem_error must rise on exactly the T-th frozen edge.
        cyc = 0;
        while (!mem_error && cyc < 3 * T) begin
            step(frz, "hang");
            cyc++;
        end
        check("timeout_edges", 32'(cyc), 32'(T));
        for (int k = 0; k < 4; k++) step(mk(2, 0, 1, 1, 2, k[0], 1, k[1], 1), "err_hold");
        check("err_sticky", {31'd0, mem_error}, 32'd1);
        do_reset();
        check("err_cleared", {31'd0, mem_error}, 32'd0);

        // Reset in the middle of a wait restarts the timeout from scratch.
        for (int k = 0; k < 5; k++) step(frz, "wait_pre_rst");
        do_reset();
        for (int k = 0; k < T - 1; k++) step(frz, "wait_post_rst");
        check("no_early_err", {31'd0, mem_error}, 32'd0);
        step(frz, "wait_last");
        check("err_after_full", {31'd0, mem_error}, 32'd1);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            in_t r;
            r = mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), 1'($urandom));
            if ((n % 400) >= 380) begin
                r.req = 1'b1;
                r.rdy = 1'b0;
            end
            if ($urandom_range(0, 199) == 0) do_reset();
            else step(r, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
